// File: rtl/sdram_tester_pkg.sv
// sdram_tester_pkg: shared types and helpers for the SDRAM self test.
// Holds the FSM state type, the address-derived pattern and counter width.
package sdram_tester_pkg;

  localparam int ERR_CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } tester_state_t;

  // Folds the address into DW bits and mixes in the seed; DW <= 32, AW <= 64.
  function automatic logic [31:0] pat(
    input logic [63:0] a,
    input logic [31:0] seed,
    input int          aw,
    input int          dw
  );
    logic [63:0] m_a;
    logic [63:0] m_d;
    logic [63:0] a_m;
    logic [63:0] r;
    m_a = (aw >= 64) ? '1 : ((64'd1 << aw) - 64'd1);
    m_d = (64'd1 << dw) - 64'd1;
    a_m = a & m_a;
    r   = (a_m & m_d) ^ ((a_m >> dw) & m_d) ^ ({32'd0, seed} & m_d);
    return r[31:0];
  endfunction

endpackage

// File: rtl/sdram_tester_checker.sv
// sdram_tester_checker: read-back compare path of the SDRAM self test.
// Tracks the expected address, counts mismatches and keeps the first one.
module sdram_tester_checker
  import sdram_tester_pkg::*;
#(
  parameter int AW = 22,
  parameter int DW = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_clr,
  input  logic                 i_active,
  input  logic                 i_rdv,
  input  logic [DW-1:0]        i_rdata,
  input  logic [DW-1:0]        i_seed,
  output logic [ERR_CNT_W-1:0] o_err_cnt,
  output logic [AW-1:0]        o_first_err_addr
);

  logic [AW-1:0]        r_exp_addr;
  logic [ERR_CNT_W-1:0] r_err_cnt;
  logic [AW-1:0]        r_first;
  logic [DW-1:0]        w_pat;
  logic                 w_take;
  logic                 w_miss;

  assign w_pat  = DW'(pat(64'(r_exp_addr), 32'(i_seed), AW, DW));
  assign w_take = i_active & i_rdv;
  assign w_miss = w_take && (i_rdata != w_pat);

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_exp_addr <= '0;
      r_err_cnt  <= '0;
      r_first    <= '0;
    end else if (w_take) begin
      r_exp_addr <= r_exp_addr + AW'(1);
      if (w_miss) begin
        if (r_err_cnt != '1)
          r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
        if (r_err_cnt == '0)
          r_first <= r_exp_addr;
      end
    end
  end

  assign o_err_cnt        = r_err_cnt;
  assign o_first_err_addr = r_first;

endmodule

// File: rtl/sdram_tester.sv
// sdram_tester: Avalon-MM write/read-back self test for the board SDRAM.
// Define SDRAM_TESTER_PIPELINE_EN to allow MAX_OUTSTANDING reads in flight.
module sdram_tester
  import sdram_tester_pkg::*;
#(
  parameter int AW              = 22,
  parameter int DW              = 16,
  parameter int LAST_ADDR       = 2**AW-1,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [DW-1:0]        seed,
  output logic [AW-1:0]        avm_address,
  output logic                 avm_write,
  output logic [DW-1:0]        avm_writedata,
  output logic                 avm_read,
  input  logic                 avm_waitrequest,
  input  logic [DW-1:0]        avm_readdata,
  input  logic                 avm_readdatavalid,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [15:0]          err_cnt,
  output logic [AW-1:0]        first_err_addr
);

`ifdef SDRAM_TESTER_PIPELINE_EN
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int LIM = MAX_OUTSTANDING;
`else
  // One read in flight at a time; larger depths are capped.
  localparam int OW = 1;
  localparam int LIM = (MAX_OUTSTANDING < 1) ? MAX_OUTSTANDING : 1;
`endif

  localparam logic [OW-1:0] L_LIMIT = OW'(LIM);
  localparam logic [AW-1:0] L_LAST  = AW'(LAST_ADDR);

  tester_state_t r_state;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_seed;
  logic [OW-1:0] r_outst;
  logic          r_pass;

  logic          w_active;
  logic          w_rdv;
  logic          w_dec;
  logic          w_wr_acc;
  logic          w_rd_acc;
  logic          w_clr;
  logic          w_last;
  logic [DW-1:0] w_wdata;
  logic [15:0]   w_err_cnt;

  assign w_active = (r_state == ST_READ) || (r_state == ST_DRAIN);
  assign w_rdv    = w_active & avm_readdatavalid;
  assign w_dec    = w_rdv && (r_outst != '0);
  assign w_clr    = (r_state == ST_IDLE) & start;
  assign w_last   = (r_addr == L_LAST);
  assign w_wdata  = DW'(pat(64'(r_addr), 32'(r_seed), AW, DW));

  assign avm_write     = (r_state == ST_WRITE);
  assign avm_read      = (r_state == ST_READ) && (r_outst < L_LIMIT);
  assign avm_address   = r_addr;
  assign avm_writedata = avm_write ? w_wdata : '0;
  assign w_wr_acc      = avm_write & ~avm_waitrequest;
  assign w_rd_acc      = avm_read & ~avm_waitrequest;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_seed  <= '0;
      r_pass  <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_WRITE;
            r_seed  <= seed;
            r_addr  <= '0;
            r_pass  <= 1'b0;
          end
        end
        ST_WRITE: begin
          if (w_wr_acc) begin
            if (w_last) begin
              r_addr  <= '0;
              r_state <= ST_READ;
            end else begin
              r_addr <= r_addr + AW'(1);
            end
          end
        end
        ST_READ: begin
          if (w_rd_acc) begin
            r_addr <= r_addr + AW'(1);
            if (w_last)
              r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if ((r_outst == '0) && !avm_readdatavalid) begin
            r_state <= ST_DONE;
            r_pass  <= (w_err_cnt == '0);
          end
        end
        ST_DONE:  r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || w_clr) begin
      r_outst <= '0;
    end else begin
      unique case ({w_rd_acc, w_dec})
        2'b10:   r_outst <= r_outst + OW'(1);
        2'b01:   r_outst <= r_outst - OW'(1);
        default: r_outst <= r_outst;
      endcase
    end
  end

  sdram_tester_checker #(
    .AW (AW),
    .DW (DW)
  ) u_checker (
    .clk              (clk),
    .reset            (reset),
    .i_clr            (w_clr),
    .i_active         (w_active),
    .i_rdv            (w_rdv),
    .i_rdata          (avm_readdata),
    .i_seed           (r_seed),
    .o_err_cnt        (w_err_cnt),
    .o_first_err_addr (first_err_addr)
  );

  assign busy    = w_active || (r_state == ST_WRITE);
  assign done    = (r_state == ST_DONE);
  assign pass    = r_pass;
  assign err_cnt = w_err_cnt;

endmodule

// File: tb/tb_sdram_tester.sv
// tb_sdram_tester: directed bench for the SDRAM self test.
// Bus slave model with latency, stalls and read corruption.
module tb_sdram_tester;

  localparam int AW   = 8;
  localparam int DW   = 16;
  localparam int LAST = 15;
`ifdef SDRAM_TESTER_PIPELINE_EN
  localparam int LIM = 8;
`else
  localparam int LIM = 1;
`endif

  typedef struct {
    int          lat;
    bit          wrand;
    int          corrupt;
    bit          ones;
    bit          restart;
    logic [15:0] seed;
    bit          exp_pass;
    int          exp_err;
    int          exp_first;
    logic [15:0] exp_m5;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [15:0]   seed = '0;
  logic [AW-1:0] addr;
  logic          wr, rd;
  logic [15:0]   wdata;
  logic          wreq = 1'b0;
  logic          rdv = 1'b0;
  logic [15:0]   rdata = '0;
  logic          busy, done, pass;
  logic [15:0]   err_cnt;
  logic [AW-1:0] first;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  sdram_tester #(
    .AW(AW), .DW(DW), .LAST_ADDR(LAST), .MAX_OUTSTANDING(8)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .seed(seed),
    .avm_address(addr), .avm_write(wr), .avm_writedata(wdata),
    .avm_read(rd), .avm_waitrequest(wreq), .avm_readdata(rdata),
    .avm_readdatavalid(rdv), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .first_err_addr(first)
  );

  // Second instance exercises the single-word range.
  logic        b_start = 1'b0;
  logic [15:0] b_seed = 16'h1111;
  logic [3:0]  b_addr;
  logic        b_wr, b_rd, b_busy, b_done, b_pass;
  logic [15:0] b_wdata;
  logic [15:0] b_rdata = '0;
  logic        b_rdv = 1'b0;
  logic [15:0] b_err;
  logic [3:0]  b_first;
  logic [15:0] b_mem = '0;
  int          b_nwr = 0;
  int          b_nrd = 0;

  sdram_tester #(
    .AW(4), .DW(16), .LAST_ADDR(0), .MAX_OUTSTANDING(8)
  ) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .seed(b_seed),
    .avm_address(b_addr), .avm_write(b_wr), .avm_writedata(b_wdata),
    .avm_read(b_rd), .avm_waitrequest(1'b0), .avm_readdata(b_rdata),
    .avm_readdatavalid(b_rdv), .busy(b_busy), .done(b_done),
    .pass(b_pass), .err_cnt(b_err), .first_err_addr(b_first)
  );

  always @(posedge clk) begin
    if (b_wr) begin
      b_mem = b_wdata;
      b_nwr++;
    end
    if (b_rd) b_nrd++;
    b_rdv   <= b_rd;
    b_rdata <= b_rd ? b_mem : 16'h0;
  end

  // Checker alone for the saturation run.
  logic        c_clr = 1'b0;
  logic        c_act = 1'b0;
  logic        c_rdv = 1'b0;
  logic [15:0] c_rdata = '0;
  logic [15:0] c_seed = 16'hA5A5;
  logic [15:0] c_err;
  logic [16:0] c_first;

  sdram_tester_checker #(.AW(17), .DW(16)) u_chk (
    .clk(clk), .reset(reset), .i_clr(c_clr), .i_active(c_act),
    .i_rdv(c_rdv), .i_rdata(c_rdata), .i_seed(c_seed),
    .o_err_cnt(c_err), .o_first_err_addr(c_first)
  );

  logic [15:0] mem [0:255] = '{default: 16'h0};
  logic        pv [0:31] = '{default: 1'b0};
  logic [15:0] pd [0:31] = '{default: 16'h0};
  int lat = 3;
  int corrupt = -1;
  bit wrand = 1'b0;
  bit ones = 1'b0;
  int outst = 0, max_outst = 0, dcnt = 0;
  int s_chk = 0, s_bad = 0, g_chk = 0, g_bad = 0;
  logic          p_stall = 1'b0, p_lastwr = 1'b0, p_wr = 1'b0, p_rd = 1'b0;
  logic [AW-1:0] p_addr = '0;
  logic [15:0]   p_wdata = '0;

  always @(posedge clk) begin
    logic racc;
    racc = rd && !wreq;
    if (p_stall) begin
      s_chk++;
      if (addr != p_addr || wr != p_wr || rd != p_rd || wdata != p_wdata)
        s_bad++;
    end
    if (p_lastwr) begin
      g_chk++;
      if (!rd) g_bad++;
    end
    p_stall  = (wr || rd) && wreq && !reset;
    p_lastwr = wr && !wreq && (addr == AW'(LAST)) && !reset;
    p_addr = addr; p_wr = wr; p_rd = rd; p_wdata = wdata;
    if (done) dcnt++;
    if (start && !busy && !done && !reset) begin
      for (int i = 0; i < 256; i++) mem[i] = 16'h0;
      outst = 0; max_outst = 0; dcnt = 0;
    end else begin
      outst = outst + (racc ? 1 : 0) - (rdv ? 1 : 0);
      if (outst > max_outst) max_outst = outst;
    end
    if (wr && !wreq) mem[addr] = wdata;
    for (int i = 0; i < 31; i++) begin
      pv[i] = pv[i+1];
      pd[i] = pd[i+1];
    end
    pv[31] = 1'b0;
    if (racc) begin
      pv[lat-1] = 1'b1;
      pd[lat-1] = ones ? 16'hFFFF :
        (mem[addr] ^ ((int'(addr) == corrupt) ? 16'h1 : 16'h0));
    end
    rdv   <= pv[0];
    rdata <= pv[0] ? pd[0] : 16'h0;
    wreq  <= wrand ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", nm, got, exp);
  endtask

  task automatic run(input vec_t v);
    int cyc;
    lat = v.lat; wrand = v.wrand; corrupt = v.corrupt; ones = v.ones;
    @(negedge clk);
    seed = v.seed; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_rise", 32'(busy), 1);
    chk("first_write", 32'(wr), 1);
    chk("first_addr", 32'(addr), 0);
    if (v.restart) begin
      repeat (3) @(negedge clk);
      seed = 16'h1234; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    cyc = 0;
    while (!done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_seen", 32'(done), 1);
    chk("busy_at_done", 32'(busy), 0);
    chk("pass", 32'(pass), 32'(v.exp_pass));
    chk("err_cnt", 32'(err_cnt), 32'(v.exp_err));
    chk("first_err", 32'(first), 32'(v.exp_first));
    chk("mem5", 32'(mem[5]), 32'(v.exp_m5));
    repeat (5) @(negedge clk);
    chk("done_once", 32'(dcnt), 1);
    chk("pass_held", 32'(pass), 32'(v.exp_pass));
    chk("outst_limit", 32'(max_outst <= LIM), 1);
  endtask

  initial begin
    vec_t tv [7];
    int cyc;
    tv[0] = '{3,  0, -1, 0, 0, 16'hA5A5, 1, 0,  0, 16'hA5A0};
    tv[1] = '{3,  1, -1, 0, 0, 16'hA5A5, 1, 0,  0, 16'hA5A0};
    tv[2] = '{3,  0,  9, 0, 0, 16'hA5A5, 0, 1,  9, 16'hA5A0};
    tv[3] = '{12, 0, -1, 0, 0, 16'hA5A5, 1, 0,  0, 16'hA5A0};
    tv[4] = '{2,  1, -1, 1, 0, 16'hA5A5, 0, 16, 0, 16'hA5A0};
    tv[5] = '{1,  0, -1, 0, 1, 16'hA5A5, 1, 0,  0, 16'hA5A0};
    tv[6] = '{5,  1,  3, 0, 0, 16'h0000, 0, 1,  3, 16'h0005};

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pass", 32'(pass), 0);
    chk("rst_err", 32'(err_cnt), 0);
    chk("rst_first", 32'(first), 0);
    chk("rst_write", 32'(wr), 0);
    chk("rst_read", 32'(rd), 0);
    chk("rst_addr", 32'(addr), 0);
    chk("rst_wdata", 32'(wdata), 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run(tv[i]);

    // Reset in the middle of the read pass; late data must be dropped.
    lat = 12; ones = 1'b1; wrand = 1'b0; corrupt = -1;
    @(negedge clk);
    seed = 16'hA5A5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!rd && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("mid_reach_read", 32'(rd), 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_read", 32'(rd), 0);
    chk("mid_rst_write", 32'(wr), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    chk("late_rdv_err", 32'(err_cnt), 0);
    chk("late_rdv_done", 32'(dcnt), 0);
    chk("late_rdv_busy", 32'(busy), 0);
    ones = 1'b0;

    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    cyc = 0;
    while (!b_done && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("one_done", 32'(b_done), 1);
    chk("one_pass", 32'(b_pass), 1);
    chk("one_err", 32'(b_err), 0);
    chk("one_writes", 32'(b_nwr), 1);
    chk("one_reads", 32'(b_nrd), 1);
    chk("one_mem", 32'(b_mem), 32'h1111);

    c_clr = 1'b1;
    @(negedge clk);
    c_clr = 1'b0; c_act = 1'b1; c_rdv = 1'b1; c_rdata = 16'hFFFF;
    @(negedge clk);
    chk("sat_first_inc", 32'(c_err), 1);
    repeat (65600) @(negedge clk);
    c_rdv = 1'b0;
    @(negedge clk);
    chk("sat_err", 32'(c_err), 32'hFFFF);
    chk("sat_first", 32'(c_first), 0);

    chk("stall_seen", 32'(s_chk > 0), 1);
    chk("stall_stable", 32'(s_bad), 0);
    chk("wr_rd_gap_seen", 32'(g_chk > 0), 1);
    chk("wr_rd_no_gap", 32'(g_bad), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
